// File: rtl/scoreboard_hazard_unit_if.sv
// ID/EX/WB hazard bus between the pipeline and the scoreboard unit.
// The master side drives the instruction info and receives the controls.
interface scoreboard_hazard_unit_if #(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
);
  localparam int RW = $clog2(NREG);

  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_rs1_used;
  logic          id_rs2_used;
  logic [RW-1:0] id_rd;
  logic          id_wenb;
  logic          id_is_load;
  logic          id_is_mc;
  logic          mc_done;
  logic          ex_redirect;
  logic          wb_wenb;
  logic [RW-1:0] wb_rd;

  logic             stall;
  logic             issue;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic [NREG-1:0]  pending;
  logic             mc_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output id_rd, id_wenb, id_is_load, id_is_mc,
    output mc_done, ex_redirect, wb_wenb, wb_rd,
    input  stall, issue, flush_if_id, flush_id_ex,
    input  pending, mc_busy, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  id_rd, id_wenb, id_is_load, id_is_mc,
    input  mc_done, ex_redirect, wb_wenb, wb_rd,
    output stall, issue, flush_if_id, flush_id_ex,
    output pending, mc_busy, stall_cnt
  );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard hazard unit: tracks load/multicycle destinations and
// produces stall, issue and flush controls for the ID stage.
module scoreboard_hazard_unit #(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  scoreboard_hazard_unit_if.slave bus
);
  typedef enum logic {IDLE, MC_BUSY} state_t;

  state_t           state;
  logic [NREG-1:0]  pend;
  logic [NREG-1:0]  pend_nxt;
  logic [CNT_W-1:0] cnt;
  logic             raw1;
  logic             raw2;
  logic             mc_hazard;
  logic             stall;
  logic             issue;
  logic             set_en;
  logic             mc_issue;

  // A same-cycle WB write to the source hides the hazard
  assign raw1 = bus.id_rs1_used && pend[bus.id_rs1]
             && !(bus.wb_wenb && bus.wb_rd == bus.id_rs1);
  assign raw2 = bus.id_rs2_used && pend[bus.id_rs2]
             && !(bus.wb_wenb && bus.wb_rd == bus.id_rs2);

  assign mc_hazard = bus.id_is_mc && (state == MC_BUSY)
                  && !bus.mc_done;

  assign stall = bus.id_valid && (raw1 || raw2 || mc_hazard)
              && !bus.ex_redirect;
  assign issue = bus.id_valid && !stall && !bus.ex_redirect;

  assign mc_issue = issue && bus.id_is_mc;
  assign set_en   = issue && bus.id_wenb
                 && (bus.id_rd != '0)
                 && (bus.id_is_load || bus.id_is_mc);

  assign bus.stall       = stall;
  assign bus.issue       = issue;
  assign bus.flush_if_id = bus.ex_redirect;
  assign bus.flush_id_ex = bus.ex_redirect || stall;
  assign bus.pending     = pend;
  assign bus.mc_busy     = (state == MC_BUSY);
  assign bus.stall_cnt   = cnt;

  // Set is applied after clear so a same-register set wins
  always_comb begin
    pend_nxt = pend;
    if (bus.wb_wenb) pend_nxt[bus.wb_rd] = 1'b0;
    if (set_en) pend_nxt[bus.id_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend <= '0;
    else pend <= pend_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (mc_issue) state <= MC_BUSY;
        MC_BUSY: if (bus.mc_done && !mc_issue) state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (stall && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: directed scenarios plus random
// traffic against a set-based reference model.
module tb_scoreboard_hazard_unit;
  localparam int NREG  = 32;
  localparam int CNT_W = 4;
  localparam int RW    = $clog2(NREG);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scoreboard_hazard_unit_if #(.NREG(NREG), .CNT_W(CNT_W)) b();

  scoreboard_hazard_unit #(.NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );

  int total = 0;
  int passed = 0;

  bit mpend[int];
  bit mbusy;
  int mcnt;
  bit e_stall, e_issue, e_fif, e_fie;

  function automatic logic [NREG-1:0] m_vec();
    logic [NREG-1:0] v;
    v = '0;
    foreach (mpend[k]) v[k] = 1'b1;
    return v;
  endfunction

  function automatic void model_eval();
    bit hz;
    hz = 0;
    if (b.id_rs1_used && mpend.exists(int'(b.id_rs1))
        && !(b.wb_wenb && b.wb_rd == b.id_rs1)) hz = 1;
    if (b.id_rs2_used && mpend.exists(int'(b.id_rs2))
        && !(b.wb_wenb && b.wb_rd == b.id_rs2)) hz = 1;
    if (b.id_is_mc && mbusy && !b.mc_done) hz = 1;
    e_stall = b.id_valid && hz && !b.ex_redirect;
    e_issue = b.id_valid && !e_stall && !b.ex_redirect;
    e_fif   = b.ex_redirect;
    e_fie   = b.ex_redirect || e_stall;
  endfunction

  function automatic void model_reset();
    mpend.delete();
    mbusy = 0;
    mcnt = 0;
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (b.wb_wenb && mpend.exists(int'(b.wb_rd)))
      mpend.delete(int'(b.wb_rd));
    if (e_issue && b.id_wenb && b.id_rd != 0
        && (b.id_is_load || b.id_is_mc))
      mpend[int'(b.id_rd)] = 1;
    if (e_issue && b.id_is_mc) mbusy = 1;
    else if (b.mc_done) mbusy = 0;
    if (e_stall && mcnt < CMAX) mcnt++;
    @(negedge clk);
  endtask

  task automatic idle_in();
    b.id_valid = 0; b.id_rs1 = '0; b.id_rs2 = '0;
    b.id_rs1_used = 0; b.id_rs2_used = 0;
    b.id_rd = '0; b.id_wenb = 0;
    b.id_is_load = 0; b.id_is_mc = 0;
    b.mc_done = 0; b.ex_redirect = 0;
    b.wb_wenb = 0; b.wb_rd = '0;
  endtask

  task automatic set_id(input logic v,
                        input logic [RW-1:0] rs1, input logic u1,
                        input logic [RW-1:0] rs2, input logic u2,
                        input logic [RW-1:0] rd, input logic we,
                        input logic ld, input logic mc);
    b.id_valid = v; b.id_rs1 = rs1; b.id_rs1_used = u1;
    b.id_rs2 = rs2; b.id_rs2_used = u2;
    b.id_rd = rd; b.id_wenb = we;
    b.id_is_load = ld; b.id_is_mc = mc;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 0;
    model_reset();
    set_id(1, 5'd5, 1, 5'd6, 1, 5'd7, 1, 1, 0);
    #3;
    total++; if (b.pending !== '0) $display("FAIL rst_pending: got %h want 0", b.pending); else passed++;
    total++; if (b.mc_busy !== 1'b0) $display("FAIL rst_mc_busy: got %b want 0", b.mc_busy); else passed++;
    total++; if (b.stall_cnt !== '0) $display("FAIL rst_stall_cnt: got %0d want 0", b.stall_cnt); else passed++;
    total++; if (b.stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", b.stall); else passed++;
    total++; if (b.issue !== 1'b1) $display("FAIL rst_issue: got %b want 1", b.issue); else passed++;
    b.ex_redirect = 1;
    #1;
    total++; if (b.issue !== 1'b0) $display("FAIL rst_redir_issue: got %b want 0", b.issue); else passed++;
    total++; if (b.flush_if_id !== 1'b1) $display("FAIL rst_redir_fif: got %b want 1", b.flush_if_id); else passed++;
    @(negedge clk);
    idle_in();
    rst = 1;
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0);
    #1;
    total++; if (b.issue !== 1'b1) $display("FAIL lu_load_issue: got %b want 1", b.issue); else passed++;
    tick();
    set_id(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (b.stall !== 1'b1) $display("FAIL lu_stall[%0d]: got %b want 1", i, b.stall); else passed++;
      total++; if (b.flush_id_ex !== 1'b1) $display("FAIL lu_fie[%0d]: got %b want 1", i, b.flush_id_ex); else passed++;
      total++; if (b.issue !== 1'b0) $display("FAIL lu_issue[%0d]: got %b want 0", i, b.issue); else passed++;
      tick();
    end
    b.wb_wenb = 1; b.wb_rd = 5'd5;
    #1;
    total++; if (b.stall !== 1'b0) $display("FAIL lu_wb_stall: got %b want 0", b.stall); else passed++;
    total++; if (b.issue !== 1'b1) $display("FAIL lu_wb_issue: got %b want 1", b.issue); else passed++;
    tick();
    idle_in();
    #1;
    total++; if (b.pending !== '0) $display("FAIL lu_pending: got %h want 0", b.pending); else passed++;
    total++; if (b.stall_cnt !== 4'd3) $display("FAIL lu_stall_cnt: got %0d want 3", b.stall_cnt); else passed++;
  endtask

  task automatic test_wb_bypass();
    do_reset();
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0);
    tick();
    set_id(1, 5'd1, 0, 5'd7, 1, 5'd8, 1, 0, 0);
    b.wb_wenb = 1; b.wb_rd = 5'd7;
    #1;
    total++; if (b.pending !== 32'h80) $display("FAIL byp_pending: got %h want 80", b.pending); else passed++;
    total++; if (b.stall !== 1'b0) $display("FAIL byp_stall: got %b want 0", b.stall); else passed++;
    total++; if (b.issue !== 1'b1) $display("FAIL byp_issue: got %b want 1", b.issue); else passed++;
    tick();
    idle_in();
    #1;
    total++; if (b.pending !== '0) $display("FAIL byp_cleared: got %h want 0", b.pending); else passed++;
  endtask

  task automatic test_multicycle();
    do_reset();
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 1);
    #1;
    total++; if (b.issue !== 1'b1) $display("FAIL mc_first_issue: got %b want 1", b.issue); else passed++;
    tick();
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd4, 1, 0, 1);
    #1;
    total++; if (b.mc_busy !== 1'b1) $display("FAIL mc_busy_set: got %b want 1", b.mc_busy); else passed++;
    total++; if (b.stall !== 1'b1) $display("FAIL mc_stall0: got %b want 1", b.stall); else passed++;
    tick();
    #1;
    total++; if (b.stall !== 1'b1) $display("FAIL mc_stall1: got %b want 1", b.stall); else passed++;
    tick();
    b.mc_done = 1;
    #1;
    total++; if (b.stall !== 1'b0) $display("FAIL mc_done_stall: got %b want 0", b.stall); else passed++;
    total++; if (b.issue !== 1'b1) $display("FAIL mc_done_issue: got %b want 1", b.issue); else passed++;
    tick();
    idle_in();
    #1;
    total++; if (b.mc_busy !== 1'b1) $display("FAIL mc_busy_hold: got %b want 1", b.mc_busy); else passed++;
    total++; if (b.pending !== 32'h18) $display("FAIL mc_pending: got %h want 18", b.pending); else passed++;
    total++; if (b.stall_cnt !== 4'd2) $display("FAIL mc_stall_cnt: got %0d want 2", b.stall_cnt); else passed++;
    b.mc_done = 1;
    tick();
    b.mc_done = 0;
    #1;
    total++; if (b.mc_busy !== 1'b0) $display("FAIL mc_busy_clear: got %b want 0", b.mc_busy); else passed++;
  endtask

  task automatic test_redirect();
    do_reset();
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0);
    tick();
    set_id(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 1, 0);
    b.ex_redirect = 1;
    #1;
    total++; if (b.stall !== 1'b0) $display("FAIL rd_stall: got %b want 0", b.stall); else passed++;
    total++; if (b.issue !== 1'b0) $display("FAIL rd_issue: got %b want 0", b.issue); else passed++;
    total++; if (b.flush_if_id !== 1'b1) $display("FAIL rd_fif: got %b want 1", b.flush_if_id); else passed++;
    total++; if (b.flush_id_ex !== 1'b1) $display("FAIL rd_fie: got %b want 1", b.flush_id_ex); else passed++;
    tick();
    idle_in();
    #1;
    total++; if (b.stall_cnt !== 4'd0) $display("FAIL rd_stall_cnt: got %0d want 0", b.stall_cnt); else passed++;
    total++; if (b.pending !== 32'h20) $display("FAIL rd_pending: got %h want 20", b.pending); else passed++;
  endtask

  task automatic test_x0_set_wins();
    do_reset();
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0);
    tick();
    idle_in();
    #1;
    total++; if (b.pending !== '0) $display("FAIL x0_pending: got %h want 0", b.pending); else passed++;
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0);
    b.wb_wenb = 1; b.wb_rd = 5'd9;
    tick();
    idle_in();
    #1;
    total++; if (b.pending !== 32'h200) $display("FAIL setwin_pending: got %h want 200", b.pending); else passed++;
  endtask

  task automatic test_saturation_reset();
    do_reset();
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0);
    tick();
    set_id(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0);
    repeat (20) tick();
    idle_in();
    #1;
    total++; if (b.stall_cnt !== 4'd15) $display("FAIL sat_cnt: got %0d want 15", b.stall_cnt); else passed++;
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 1);
    tick();
    idle_in();
    #1;
    total++; if (b.mc_busy !== 1'b1) $display("FAIL sat_busy_pre: got %b want 1", b.mc_busy); else passed++;
    #1;
    rst = 0;
    model_reset();
    #1;
    total++; if (b.mc_busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", b.mc_busy); else passed++;
    total++; if (b.pending !== '0) $display("FAIL arst_pending: got %h want 0", b.pending); else passed++;
    total++; if (b.stall_cnt !== '0) $display("FAIL arst_cnt: got %0d want 0", b.stall_cnt); else passed++;
    @(negedge clk);
    rst = 1;
    b.mc_done = 1;
    tick();
    b.mc_done = 0;
    #1;
    total++; if (b.mc_busy !== 1'b0) $display("FAIL stray_done_busy: got %b want 0", b.mc_busy); else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 99) do_reset();
      b.id_valid    = ($urandom_range(3) != 0);
      b.id_rs1      = RW'($urandom_range(7));
      b.id_rs2      = RW'($urandom_range(7));
      b.id_rs1_used = $urandom_range(1);
      b.id_rs2_used = $urandom_range(1);
      b.id_rd       = RW'($urandom_range(7));
      b.id_wenb     = ($urandom_range(3) != 0);
      b.id_is_load  = ($urandom_range(9) < 3);
      b.id_is_mc    = !b.id_is_load && ($urandom_range(9) < 2);
      b.mc_done     = mbusy ? ($urandom_range(9) < 3) : ($urandom_range(19) == 0);
      b.ex_redirect = ($urandom_range(9) == 0);
      b.wb_wenb     = ($urandom_range(9) < 4);
      b.wb_rd       = RW'($urandom_range(7));
      model_eval();
      #1;
      total++; if (b.stall !== e_stall) $display("FAIL rnd_stall@%0d: got %b want %b", i, b.stall, e_stall); else passed++;
      total++; if (b.issue !== e_issue) $display("FAIL rnd_issue@%0d: got %b want %b", i, b.issue, e_issue); else passed++;
      total++; if (b.flush_if_id !== e_fif) $display("FAIL rnd_fif@%0d: got %b want %b", i, b.flush_if_id, e_fif); else passed++;
      total++; if (b.flush_id_ex !== e_fie) $display("FAIL rnd_fie@%0d: got %b want %b", i, b.flush_id_ex, e_fie); else passed++;
      total++; if (b.pending !== m_vec()) $display("FAIL rnd_pending@%0d: got %h want %h", i, b.pending, m_vec()); else passed++;
      total++; if (b.mc_busy !== mbusy) $display("FAIL rnd_busy@%0d: got %b want %b", i, b.mc_busy, mbusy); else passed++;
      total++; if (int'(b.stall_cnt) !== mcnt) $display("FAIL rnd_cnt@%0d: got %0d want %0d", i, b.stall_cnt, mcnt); else passed++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0;
    idle_in();
    test_reset();
    test_load_use();
    test_wb_bypass();
    test_multicycle();
    test_redirect();
    test_x0_set_wins();
    test_saturation_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
